// File: rtl/cpu_sequencer.sv
// Control sequencer for the 8-bit accumulator CPU: fetch, decode, execute.
// Latency: 4 to 9 cycles per instruction; instr_done marks the final cycle.
// Backpressure: run low in FETCH_0 stalls before the next instruction, with all outputs 0.
module cpu_sequencer #(
  parameter logic [2:0] ALU_ADD_SEL = 3'b000,
  parameter logic [2:0] ALU_SUB_SEL = 3'b001,
  parameter int         Z_BIT       = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] IR,
  input  logic [3:0] CCR_Result,
  output logic       IR_Load,
  output logic       MAR_Load,
  output logic       PC_Load,
  output logic       PC_Inc,
  output logic       A_Load,
  output logic       B_Load,
  output logic       CCR_Load,
  output logic [2:0] ALU_Sel,
  output logic [1:0] Bus1_Sel,
  output logic [1:0] Bus2_Sel,
  output logic       write,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam logic [7:0] OP_LDA_IMM = 8'h86;
  localparam logic [7:0] OP_LDA_DIR = 8'h87;
  localparam logic [7:0] OP_LDB_IMM = 8'h88;
  localparam logic [7:0] OP_LDB_DIR = 8'h89;
  localparam logic [7:0] OP_STA_DIR = 8'h96;
  localparam logic [7:0] OP_ADD_AB  = 8'h42;
  localparam logic [7:0] OP_SUB_AB  = 8'h43;
  localparam logic [7:0] OP_BRA     = 8'h20;
  localparam logic [7:0] OP_BEQ     = 8'h23;

  localparam logic [1:0] B1_PC  = 2'b00;
  localparam logic [1:0] B1_A   = 2'b01;
  localparam logic [1:0] B1_B   = 2'b10;
  localparam logic [1:0] B2_ALU = 2'b00;
  localparam logic [1:0] B2_B1  = 2'b01;
  localparam logic [1:0] B2_MEM = 2'b10;

  // 30 states in 5 bits; the two spare encodings fall into the default arms.
  typedef enum logic [4:0] {
    S_FETCH_0, S_FETCH_1, S_FETCH_2, S_DECODE_3,
    S_LDA_IMM_4, S_LDA_IMM_5, S_LDA_IMM_6,
    S_LDB_IMM_4, S_LDB_IMM_5, S_LDB_IMM_6,
    S_LDA_DIR_4, S_LDA_DIR_5, S_LDA_DIR_6, S_LDA_DIR_7, S_LDA_DIR_8,
    S_LDB_DIR_4, S_LDB_DIR_5, S_LDB_DIR_6, S_LDB_DIR_7, S_LDB_DIR_8,
    S_STA_DIR_4, S_STA_DIR_5, S_STA_DIR_6, S_STA_DIR_7,
    S_ADD_AB_4, S_SUB_AB_4,
    S_BRA_4, S_BRA_5, S_BRA_6,
    S_BEQ_NT_4
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_illegal;
  logic   w_unused_ccr;

  // Only the Z flag steers the sequence; the other flags are carried for completeness.
  assign w_unused_ccr = ^CCR_Result;

  // State register; reset parks the FSM in FETCH_0 so the first free cycle fetches.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_FETCH_0;
    else       r_state <= w_next;
  end

  // Next-state selection and state-decoded strobes; reset forces every output low.
  always_comb begin
    w_next     = S_FETCH_0;
    w_illegal  = 1'b0;
    IR_Load    = 1'b0;
    MAR_Load   = 1'b0;
    PC_Load    = 1'b0;
    PC_Inc     = 1'b0;
    A_Load     = 1'b0;
    B_Load     = 1'b0;
    CCR_Load   = 1'b0;
    ALU_Sel    = ALU_ADD_SEL;
    Bus1_Sel   = B1_PC;
    Bus2_Sel   = B2_ALU;
    write      = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;

    case (r_state)
      S_FETCH_0:   w_next = run ? S_FETCH_1 : S_FETCH_0;
      S_FETCH_1:   w_next = S_FETCH_2;
      S_FETCH_2:   w_next = S_DECODE_3;
      S_DECODE_3: begin
        case (IR)
          OP_LDA_IMM: w_next = S_LDA_IMM_4;
          OP_LDB_IMM: w_next = S_LDB_IMM_4;
          OP_LDA_DIR: w_next = S_LDA_DIR_4;
          OP_LDB_DIR: w_next = S_LDB_DIR_4;
          OP_STA_DIR: w_next = S_STA_DIR_4;
          OP_ADD_AB:  w_next = S_ADD_AB_4;
          OP_SUB_AB:  w_next = S_SUB_AB_4;
          OP_BRA:     w_next = S_BRA_4;
          OP_BEQ:     w_next = CCR_Result[Z_BIT] ? S_BRA_4 : S_BEQ_NT_4;
          default:    w_illegal = 1'b1;
        endcase
      end
      S_LDA_IMM_4: w_next = S_LDA_IMM_5;
      S_LDA_IMM_5: w_next = S_LDA_IMM_6;
      S_LDB_IMM_4: w_next = S_LDB_IMM_5;
      S_LDB_IMM_5: w_next = S_LDB_IMM_6;
      S_LDA_DIR_4: w_next = S_LDA_DIR_5;
      S_LDA_DIR_5: w_next = S_LDA_DIR_6;
      S_LDA_DIR_6: w_next = S_LDA_DIR_7;
      S_LDA_DIR_7: w_next = S_LDA_DIR_8;
      S_LDB_DIR_4: w_next = S_LDB_DIR_5;
      S_LDB_DIR_5: w_next = S_LDB_DIR_6;
      S_LDB_DIR_6: w_next = S_LDB_DIR_7;
      S_LDB_DIR_7: w_next = S_LDB_DIR_8;
      S_STA_DIR_4: w_next = S_STA_DIR_5;
      S_STA_DIR_5: w_next = S_STA_DIR_6;
      S_STA_DIR_6: w_next = S_STA_DIR_7;
      S_BRA_4:     w_next = S_BRA_5;
      S_BRA_5:     w_next = S_BRA_6;
      default:     w_next = S_FETCH_0;
    endcase

    if (!reset) begin
      case (r_state)
        S_FETCH_0: begin
          // A stalled fetch drives nothing, so MAR is not disturbed while waiting.
          MAR_Load = run;
          Bus2_Sel = run ? B2_B1 : B2_ALU;
        end
        S_FETCH_1, S_LDA_IMM_5, S_LDB_IMM_5, S_LDA_DIR_5, S_LDB_DIR_5, S_STA_DIR_5:
          PC_Inc = 1'b1;
        S_FETCH_2: begin
          Bus2_Sel = B2_MEM;
          IR_Load  = 1'b1;
        end
        S_DECODE_3: begin
          illegal_op = w_illegal;
          instr_done = w_illegal;
        end
        S_LDA_IMM_4, S_LDB_IMM_4, S_LDA_DIR_4, S_LDB_DIR_4, S_STA_DIR_4, S_BRA_4: begin
          Bus2_Sel = B2_B1;
          MAR_Load = 1'b1;
        end
        S_LDA_IMM_6, S_LDA_DIR_8: begin
          Bus2_Sel   = B2_MEM;
          A_Load     = 1'b1;
          instr_done = 1'b1;
        end
        S_LDB_IMM_6, S_LDB_DIR_8: begin
          Bus2_Sel   = B2_MEM;
          B_Load     = 1'b1;
          instr_done = 1'b1;
        end
        S_LDA_DIR_6, S_LDB_DIR_6, S_STA_DIR_6: begin
          Bus2_Sel = B2_MEM;
          MAR_Load = 1'b1;
        end
        S_STA_DIR_7: begin
          Bus1_Sel   = B1_A;
          write      = 1'b1;
          instr_done = 1'b1;
        end
        S_ADD_AB_4, S_SUB_AB_4: begin
          Bus1_Sel   = B1_B;
          Bus2_Sel   = B2_ALU;
          ALU_Sel    = (r_state == S_SUB_AB_4) ? ALU_SUB_SEL : ALU_ADD_SEL;
          A_Load     = 1'b1;
          CCR_Load   = 1'b1;
          instr_done = 1'b1;
        end
        S_BRA_6: begin
          Bus2_Sel   = B2_MEM;
          PC_Load    = 1'b1;
          instr_done = 1'b1;
        end
        S_BEQ_NT_4: begin
          PC_Inc     = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios plus random instruction stream.
// Expected strobes come from a per-opcode cycle table built from the instruction set rules.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_cpu_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       run;
  logic [7:0] IR;
  logic [3:0] CCR_Result;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load;
  logic [2:0] ALU_Sel;
  logic [1:0] Bus1_Sel, Bus2_Sel;
  logic       write, instr_done, illegal_op;

  int n_vec = 0;
  int n_err = 0;

  // Packed view: {IR_Load,MAR_Load,PC_Load,PC_Inc,A_Load,B_Load,CCR_Load,ALU_Sel,Bus1_Sel,Bus2_Sel,write,instr_done,illegal_op}
  localparam logic [16:0] IRL    = 17'h10000;
  localparam logic [16:0] MARL   = 17'h08000;
  localparam logic [16:0] PCL    = 17'h04000;
  localparam logic [16:0] PCI    = 17'h02000;
  localparam logic [16:0] AL     = 17'h01000;
  localparam logic [16:0] BL     = 17'h00800;
  localparam logic [16:0] CCRL   = 17'h00400;
  localparam logic [16:0] ALUSUB = 17'h00080;
  localparam logic [16:0] B1A    = 17'h00020;
  localparam logic [16:0] B1B    = 17'h00040;
  localparam logic [16:0] B2B1   = 17'h00008;
  localparam logic [16:0] B2MEM  = 17'h00010;
  localparam logic [16:0] WR     = 17'h00004;
  localparam logic [16:0] DONE   = 17'h00002;
  localparam logic [16:0] ILL    = 17'h00001;

  logic [16:0] exp_q[$];

  cpu_sequencer dut (
    .clock(clock), .reset(reset), .run(run), .IR(IR), .CCR_Result(CCR_Result),
    .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
    .A_Load(A_Load), .B_Load(B_Load), .CCR_Load(CCR_Load), .ALU_Sel(ALU_Sel),
    .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel), .write(write),
    .instr_done(instr_done), .illegal_op(illegal_op)
  );

  always #5 clock = ~clock;

  function automatic logic [16:0] obs();
    return {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
            ALU_Sel, Bus1_Sel, Bus2_Sel, write, instr_done, illegal_op};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: list of per-cycle strobe sets for one instruction, from FETCH_0 to its last cycle.
  task automatic model_instr(input logic [7:0] op, input logic z);
    logic [16:0] fetch_op;
    fetch_op = MARL | B2B1;
    exp_q.delete();
    exp_q.push_back(fetch_op);
    exp_q.push_back(PCI);
    exp_q.push_back(IRL | B2MEM);
    case (op)
      8'h86, 8'h88: begin
        exp_q.push_back('0); exp_q.push_back(fetch_op); exp_q.push_back(PCI);
        exp_q.push_back(B2MEM | DONE | ((op == 8'h86) ? AL : BL));
      end
      8'h87, 8'h89: begin
        exp_q.push_back('0); exp_q.push_back(fetch_op); exp_q.push_back(PCI);
        exp_q.push_back(B2MEM | MARL); exp_q.push_back('0);
        exp_q.push_back(B2MEM | DONE | ((op == 8'h87) ? AL : BL));
      end
      8'h96: begin
        exp_q.push_back('0); exp_q.push_back(fetch_op); exp_q.push_back(PCI);
        exp_q.push_back(B2MEM | MARL); exp_q.push_back(B1A | WR | DONE);
      end
      8'h42: begin
        exp_q.push_back('0); exp_q.push_back(B1B | AL | CCRL | DONE);
      end
      8'h43: begin
        exp_q.push_back('0); exp_q.push_back(B1B | ALUSUB | AL | CCRL | DONE);
      end
      8'h20, 8'h23: begin
        exp_q.push_back('0);
        if (op == 8'h20 || z) begin
          exp_q.push_back(fetch_op); exp_q.push_back('0); exp_q.push_back(B2MEM | PCL | DONE);
        end else begin
          exp_q.push_back(PCI | DONE);
        end
      end
      default: exp_q.push_back(DONE | ILL);
    endcase
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b1; IR = 8'h86; CCR_Result = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_vec++;
      if (obs() !== 17'h0) begin
        n_err++; $display("FAIL reset_hold cyc%0d got %h want 00000", i, obs());
      end
      tick();
    end
    reset = 1'b0; IR = 8'h00;
    @(negedge clock);
    n_vec++;
    if ({MAR_Load, Bus1_Sel, Bus2_Sel} !== 5'b1_00_01) begin
      n_err++; $display("FAIL reset_cyc0 got %b want 10001", {MAR_Load, Bus1_Sel, Bus2_Sel});
    end
    tick();
    tick();
    @(negedge clock);
    n_vec++;
    if ({IR_Load, Bus2_Sel} !== 3'b1_10) begin
      n_err++; $display("FAIL reset_cyc2 got %b want 110", {IR_Load, Bus2_Sel});
    end
    tick();
    tick();
  endtask

  task automatic test_lda_imm();
    IR = 8'h86; run = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      n_vec++;
      if (c == 6 && {A_Load, Bus2_Sel, instr_done} !== 4'b1_10_1) begin
        n_err++; $display("FAIL lda_load got %b want 1101", {A_Load, Bus2_Sel, instr_done});
      end else if (c != 6 && {A_Load, instr_done} !== 2'b00) begin
        n_err++; $display("FAIL lda_early cyc%0d got %b want 00", c, {A_Load, instr_done});
      end
      tick();
    end
    @(negedge clock);
    n_vec++;
    if (obs() !== (MARL | B2B1)) begin
      n_err++; $display("FAIL lda_next_fetch got %h want %h", obs(), MARL | B2B1);
    end
    run = 1'b0;
    tick();
    run = 1'b1;
  endtask

  task automatic test_sta_dir();
    IR = 8'h96; run = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      n_vec++;
      if (write !== (c == 7) || MAR_Load !== (c == 0 || c == 4 || c == 6)) begin
        n_err++; $display("FAIL sta_strobes cyc%0d got write=%b mar=%b", c, write, MAR_Load);
      end
      if (c == 7) begin
        n_vec++;
        if ({Bus1_Sel, IR_Load, MAR_Load, PC_Load, A_Load, B_Load, CCR_Load} !== 8'b01_000000) begin
          n_err++; $display("FAIL sta_store got %b want 01000000",
                            {Bus1_Sel, IR_Load, MAR_Load, PC_Load, A_Load, B_Load, CCR_Load});
        end
      end
      tick();
    end
  endtask

  task automatic test_beq();
    IR = 8'h23; run = 1'b1; CCR_Result = 4'b0100;
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      n_vec++;
      if (PC_Load !== (c == 6) || instr_done !== (c == 6)) begin
        n_err++; $display("FAIL beq_taken cyc%0d got pcl=%b done=%b", c, PC_Load, instr_done);
      end
      tick();
      if (c >= 3) CCR_Result = 4'($urandom);
    end
    CCR_Result = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      n_vec++;
      if (PC_Inc !== (c == 1 || c == 4) || instr_done !== (c == 4) || PC_Load !== 1'b0) begin
        n_err++; $display("FAIL beq_not_taken cyc%0d got pci=%b done=%b pcl=%b",
                          c, PC_Inc, instr_done, PC_Load);
      end
      tick();
      if (c >= 3) CCR_Result = 4'($urandom);
    end
  endtask

  task automatic test_alu_illegal();
    IR = 8'h43; run = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (c == 4) begin
        n_vec++;
        if ({ALU_Sel, Bus1_Sel, Bus2_Sel, A_Load, CCR_Load, instr_done} !== 10'b001_10_00_111) begin
          n_err++; $display("FAIL sub_exec got %b want 0011000111",
                            {ALU_Sel, Bus1_Sel, Bus2_Sel, A_Load, CCR_Load, instr_done});
        end
      end
      tick();
    end
    IR = 8'hFF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      n_vec++;
      if ({illegal_op, instr_done} !== ((c == 3) ? 2'b11 : 2'b00)) begin
        n_err++; $display("FAIL illegal cyc%0d got %b", c, {illegal_op, instr_done});
      end
      tick();
    end
    @(negedge clock);
    n_vec++;
    if (obs() !== (MARL | B2B1)) begin
      n_err++; $display("FAIL illegal_next_fetch got %h want %h", obs(), MARL | B2B1);
    end
    run = 1'b0;
    tick();
    run = 1'b1;
  endtask

  task automatic test_stall();
    run = 1'b0; IR = 8'h42;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      n_vec++;
      if (obs() !== 17'h0) begin
        n_err++; $display("FAIL stall cyc%0d got %h want 00000", c, obs());
      end
      tick();
    end
    run = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      n_vec++;
      if (MAR_Load !== (c == 0) || instr_done !== (c == 4)) begin
        n_err++; $display("FAIL stall_resume cyc%0d got mar=%b done=%b", c, MAR_Load, instr_done);
      end
      tick();
    end
  endtask

  task automatic test_reset_abort();
    IR = 8'h96; run = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      n_vec++;
      if (write !== 1'b0) begin
        n_err++; $display("FAIL abort_pre cyc%0d got write=%b want 0", c, write);
      end
      tick();
    end
    reset = 1'b1;
    @(negedge clock);
    n_vec++;
    if (obs() !== 17'h0) begin
      n_err++; $display("FAIL abort_quiet got %h want 00000", obs());
    end
    tick();
    reset = 1'b0;
    @(negedge clock);
    n_vec++;
    if (obs() !== (MARL | B2B1)) begin
      n_err++; $display("FAIL abort_refetch got %h want %h", obs(), MARL | B2B1);
    end
    run = 1'b0;
    tick();
    run = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] ops [12];
    logic [7:0] op;
    logic [3:0] ccr;
    logic [16:0] e;
    int k;
    int stall;
    ops = '{8'h86, 8'h88, 8'h87, 8'h89, 8'h96, 8'h42, 8'h43, 8'h20, 8'h23, 8'h23, 8'h00, 8'hFF};
    for (int n = 0; n < 150; n++) begin
      k   = $urandom_range(0, 11);
      op  = (k == 11) ? 8'($urandom) : ops[k];
      ccr = 4'($urandom);
      IR = op; CCR_Result = ccr;
      stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run = 1'b0;
      for (int s = 0; s < stall; s++) begin
        @(negedge clock);
        n_vec++;
        if (obs() !== 17'h0) begin
          n_err++; $display("FAIL rnd_stall op=%h got %h want 00000", op, obs());
        end
        tick();
      end
      run = 1'b1;
      model_instr(op, ccr[2]);
      for (int c = 0; c < exp_q.size(); c++) begin
        e = exp_q[c];
        @(negedge clock);
        n_vec++;
        if (obs() !== e) begin
          n_err++; $display("FAIL rnd_seq op=%h ccr=%b cyc%0d got %h want %h", op, ccr, c, obs(), e);
        end
        n_vec++;
        if ((PC_Load & PC_Inc) ||
            (write & (IR_Load | MAR_Load | PC_Load | A_Load | B_Load | CCR_Load)) ||
            !$onehot0({A_Load, B_Load, IR_Load, MAR_Load, PC_Load})) begin
          n_err++; $display("FAIL rnd_invariant op=%h cyc%0d got %h", op, c, obs());
        end
        tick();
        run = 1'($urandom);
        if (c >= 3) CCR_Result = 4'($urandom);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lda_imm();
    test_sta_dir();
    test_beq();
    test_alu_illegal();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
